// File: rtl/word_stat_pkg.sv
// Shared types and helpers for the word_stat_counter keyword path.
// Case handling is selected in word_stat_counter via WORD_STAT_CASE_SENSITIVE_EN.
package word_stat_pkg;

    typedef enum logic [1:0] {
        ST_GAP   = 2'd0,
        ST_MATCH = 2'd1,
        ST_MISS  = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_UC_A     = 8'h41;
    localparam logic [7:0] ASCII_UC_Z     = 8'h5A;
    localparam logic [7:0] ASCII_LC_A     = 8'h61;
    localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
    localparam logic [7:0] CASE_FOLD_MASK = 8'hDF;

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= ASCII_UC_A) && (c <= ASCII_UC_Z)) ||
               ((c >= ASCII_LC_A) && (c <= ASCII_LC_Z));
    endfunction

    function automatic logic [7:0] fold_case(input logic [7:0] c);
        return c & CASE_FOLD_MASK;
    endfunction

endpackage

// File: rtl/word_stat_pat.sv
// Pattern register file: append-only write port, length/full tracking and a
// combinational read of one character at the FSM's current word position.
module word_stat_pat
    import word_stat_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [7:0]       wr_char,
    input  logic [LEN_W-1:0] rd_idx,
    output logic [7:0]       rd_char,
    output logic [LEN_W-1:0] pat_len,
    output logic             full
);

    localparam int               IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0][7:0] pat;
    logic [IDX_W-1:0]        wr_sel;
    logic [IDX_W-1:0]        rd_sel;

    assign full   = (pat_len == LEN_MAX);
    assign wr_sel = pat_len[IDX_W-1:0];
    assign rd_sel = rd_idx[IDX_W-1:0];

    // idx can sit at pat_len == MAX_LEN after a full-length prefix; read 0 there.
    assign rd_char = (rd_idx < LEN_MAX) ? pat[rd_sel] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat     <= '0;
            pat_len <= '0;
        end else if (clr) begin
            pat_len <= '0;
        end else if (we && !full) begin
            pat[wr_sel] <= wr_char;
            pat_len     <= pat_len + 1'b1;
        end
    end

endmodule

// File: rtl/word_stat_counter.sv
// Streaming keyword counter: splits ASCII input into letter-run words and counts
// words equal to a programmable pattern. WORD_STAT_CASE_SENSITIVE_EN disables case folding.
module word_stat_counter
    import word_stat_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    input  logic             in_last,
    input  logic             cfg_clr,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_char,
    output logic [CNT_W-1:0] count,
    output logic             match,
    output logic             overflow,
    output logic             cfg_full
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] idx, idx_nxt, idx_inc;
    logic [LEN_W-1:0] pat_len;
    logic [7:0]       pat_char;
    logic             letter;
    logic             char_eq;
    logic             step_ok;
    logic             hit;
    logic             sat;

    word_stat_pat #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_pat (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cfg_clr),
        .we      (cfg_we),
        .wr_char (cfg_char),
        .rd_idx  (idx),
        .rd_char (pat_char),
        .pat_len (pat_len),
        .full    (cfg_full)
    );

    assign letter = is_letter(in_char);

`ifdef WORD_STAT_CASE_SENSITIVE_EN
    assign char_eq = (in_char == pat_char);
`else
    assign char_eq = (fold_case(in_char) == fold_case(pat_char));
`endif

    // idx is 0 in GAP, so the same test covers the first letter and later ones.
    assign step_ok = (state != ST_MISS) && (idx < pat_len) && char_eq;
    assign idx_inc = idx + 1'b1;
    assign sat     = &count;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        hit       = 1'b0;
        if (cfg_clr) begin
            state_nxt = ST_GAP;
            idx_nxt   = '0;
        end else if (cfg_we) begin
            // The pattern may change under a partial word, so that word is void.
            if (state != ST_GAP) begin
                state_nxt = ST_MISS;
                idx_nxt   = '0;
            end
        end else if (in_valid) begin
            if (letter) begin
                if (in_last) begin
                    hit       = step_ok && (idx_inc == pat_len);
                    state_nxt = ST_GAP;
                    idx_nxt   = '0;
                end else if (step_ok) begin
                    state_nxt = ST_MATCH;
                    idx_nxt   = idx_inc;
                end else begin
                    state_nxt = ST_MISS;
                    idx_nxt   = '0;
                end
            end else begin
                hit       = (state == ST_MATCH) && (idx == pat_len);
                state_nxt = ST_GAP;
                idx_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_GAP;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Pulse only on a real increment; a saturated hit just flags overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            match    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            match <= hit && !sat;
            if (hit) begin
                if (sat) overflow <= 1'b1;
                else     count    <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_stat_counter.sv
// Bench for word_stat_counter: vector table, hand-written corner sequences and a
// randomized run against a word-level reference model.
module tb_word_stat_counter;

    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef WORD_STAT_CASE_SENSITIVE_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_char = 8'h00;
    logic             in_last = 1'b0;
    logic             cfg_clr = 1'b0;
    logic             cfg_we = 1'b0;
    logic [7:0]       cfg_char = 8'h00;
    logic [CNT_W-1:0] count;
    logic             match;
    logic             overflow;
    logic             cfg_full;

    always #5 clk = ~clk;

    word_stat_counter #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_char  (in_char),
        .in_last  (in_last),
        .cfg_clr  (cfg_clr),
        .cfg_we   (cfg_we),
        .cfg_char (cfg_char),
        .count    (count),
        .match    (match),
        .overflow (overflow),
        .cfg_full (cfg_full)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_last = 1'b0; cfg_clr = 1'b0; cfg_we = 1'b0;
        in_char = 8'h00; cfg_char = 8'h00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load(input string p);
        for (int i = 0; i < p.len(); i++) begin
            cfg_we = 1'b1; cfg_char = p[i];
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic stream(input string s, input bit lastf, output int pulses, output int pos);
        pulses = 0; pos = -1;
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1; in_char = s[i];
            in_last  = lastf && (i == s.len() - 1);
            tick();
            if (match) begin pulses++; pos = i; end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        string pat;
        string str;
        bit    lastf;
        int    exp_cnt;
        int    exp_ovf;
        int    exp_pulses;
        int    exp_pos;
    } vec_t;

    vec_t vecs[$];

    // ---------------- reference model (word level) ----------------
    byte m_pat[$];
    byte m_word[$];
    bit  m_taint;
    int  m_cnt;
    bit  m_ovf;

    function automatic byte upc(input byte c);
        if (c >= "a" && c <= "z") return byte'(c - 8'd32);
        return c;
    endfunction

    function automatic bit m_letter(input byte c);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction

    function automatic bit word_eq();
        if (m_pat.size() == 0 || m_word.size() != m_pat.size()) return 1'b0;
        for (int i = 0; i < m_word.size(); i++) begin
            if (CS ? (m_word[i] != m_pat[i]) : (upc(m_word[i]) != upc(m_pat[i])))
                return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit close_word();
        bit pulse = 1'b0;
        if (!m_taint && word_eq()) begin
            if (m_cnt == CNT_MAX) m_ovf = 1'b1;
            else begin m_cnt++; pulse = 1'b1; end
        end
        m_word.delete();
        m_taint = 1'b0;
        return pulse;
    endfunction

    task automatic model_reset();
        m_pat.delete(); m_word.delete();
        m_taint = 1'b0; m_cnt = 0; m_ovf = 1'b0;
    endtask

    task automatic rstep(input bit clr, input bit we, input byte wc,
                         input bit v, input byte c, input bit l);
        bit exp_pulse = 1'b0;
        cfg_clr = clr; cfg_we = we; cfg_char = wc;
        in_valid = v; in_char = c; in_last = l;
        if (clr) begin
            m_pat.delete(); m_word.delete(); m_taint = 1'b0;
        end else if (we) begin
            if (m_word.size() > 0) m_taint = 1'b1;
            if (m_pat.size() < MAX_LEN) m_pat.push_back(wc);
        end else if (v) begin
            if (m_letter(c)) begin
                m_word.push_back(c);
                if (l) exp_pulse = close_word();
            end else begin
                exp_pulse = close_word();
            end
        end
        tick();
        chk("rnd_count", int'(count), m_cnt);
        chk("rnd_match", int'(match), int'(exp_pulse));
        chk("rnd_overflow", int'(overflow), int'(m_ovf));
        chk("rnd_cfg_full", int'(cfg_full), int'(m_pat.size() == MAX_LEN));
    endtask

    string alpha = "abAB .x";
    string pat_alpha = "abAB";

    initial begin
        int pulses, pos, plen;
        bit p1, p2;

        // reset state
        #1;
        chk("reset_count", int'(count), 0);
        chk("reset_match", int'(match), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_cfg_full", int'(cfg_full), 0);
        do_reset();

        // ---------------- vector table ----------------
        vecs.push_back('{"buaa", "#buaa?", 1'b0, 1, 0, 1, 5});
        vecs.push_back('{"buaa", "buaa# bubuaa BUAAa a bUa zbuaa Buaaa bnuaa buaaaar? bua buaa",
                         1'b1, 2, 0, 2, -1});
        vecs.push_back('{"buaa", "BUAA bUaA ", 1'b0, CS ? 0 : 2, 0, CS ? 0 : 2, -1});
        vecs.push_back('{"BuAa", "buaa ", 1'b0, CS ? 0 : 1, 0, CS ? 0 : 1, -1});
        vecs.push_back('{"ab", "ab ab ab ab ab ", 1'b0, 3, 1, 3, 8});
        vecs.push_back('{"", "x y ", 1'b0, 0, 0, 0, -1});
        vecs.push_back('{"abcd", "abcd abc abcde dabc", 1'b1, 1, 0, 1, 4});
        vecs.push_back('{"buaa", "  buaa   buaa", 1'b0, 1, 0, 1, 6});
        vecs.push_back('{"ab", "ab", 1'b1, 1, 0, 1, 1});
        vecs.push_back('{"b", "b1b;bb b", 1'b1, 3, 0, 3, 7});
        vecs.push_back('{"a.", "a. a.a ", 1'b0, 0, 0, 0, -1});

        foreach (vecs[k]) begin
            do_reset();
            load(vecs[k].pat);
            stream(vecs[k].str, vecs[k].lastf, pulses, pos);
            chk($sformatf("vec%0d_count", k), int'(count), vecs[k].exp_cnt);
            chk($sformatf("vec%0d_overflow", k), int'(overflow), vecs[k].exp_ovf);
            chk($sformatf("vec%0d_pulses", k), pulses, vecs[k].exp_pulses);
            if (vecs[k].exp_pos >= 0)
                chk($sformatf("vec%0d_pulse_pos", k), pos, vecs[k].exp_pos);
        end

        // ---------------- back-to-back terminators ----------------
        do_reset();
        load("a");
        in_valid = 1'b1; in_char = "a"; in_last = 1'b1;
        tick(); p1 = match;
        tick(); p2 = match;
        in_valid = 1'b0; in_last = 1'b0;
        chk("b2b_pulse1", int'(p1), 1);
        chk("b2b_pulse2", int'(p2), 1);
        chk("b2b_count", int'(count), 2);

        // ---------------- configuration edges ----------------
        do_reset();
        load("wxyzq");
        chk("cfg_full_set", int'(cfg_full), 1);
        stream("wxyz ", 1'b0, pulses, pos);
        chk("cfg_len4_count", int'(count), 1);
        cfg_we = 1'b1; cfg_char = "k"; in_valid = 1'b1; in_char = "x";
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        stream("wxyz ", 1'b0, pulses, pos);
        chk("cfg_drop_count", int'(count), 2);
        stream("wx", 1'b0, pulses, pos);
        cfg_we = 1'b1; cfg_char = "k";
        tick();
        cfg_we = 1'b0;
        stream("yz ", 1'b0, pulses, pos);
        chk("cfg_we_midword", int'(count), 2);
        cfg_clr = 1'b1; cfg_we = 1'b1; cfg_char = "x";
        tick();
        cfg_clr = 1'b0; cfg_we = 1'b0;
        chk("cfg_clr_full", int'(cfg_full), 0);
        stream("x y ", 1'b0, pulses, pos);
        chk("cfg_clr_count", int'(count), 2);

        // ---------------- saturation stickiness ----------------
        do_reset();
        load("ab");
        stream("ab ab ab ab ", 1'b0, pulses, pos);
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        chk("sat_clr_overflow", int'(overflow), 1);
        chk("sat_clr_count", int'(count), 3);
        mid_reset();
        chk("sat_rst_overflow", int'(overflow), 0);
        chk("sat_rst_count", int'(count), 0);
        release_reset();

        // ---------------- reset mid-word ----------------
        load("buaa");
        stream("buaa bu", 1'b0, pulses, pos);
        chk("rmw_pre_count", int'(count), 1);
        chk("rmw_pre_full", int'(cfg_full), 1);
        mid_reset();
        chk("rmw_count", int'(count), 0);
        chk("rmw_match", int'(match), 0);
        chk("rmw_overflow", int'(overflow), 0);
        chk("rmw_cfg_full", int'(cfg_full), 0);
        release_reset();
        load("buaa");
        stream("aa buaa ", 1'b0, pulses, pos);
        chk("rmw_reload_count", int'(count), 1);

        // ---------------- randomized run ----------------
        for (int t = 0; t < 40; t++) begin
            do_reset();
            model_reset();
            plen = $urandom_range(0, MAX_LEN + 1);
            for (int i = 0; i < plen; i++)
                rstep(1'b0, 1'b1, byte'(pat_alpha[$urandom_range(0, 3)]), 1'b0, 8'h00, 1'b0);
            for (int c = 0; c < 40; c++) begin
                int r = $urandom_range(0, 99);
                byte ch = byte'(alpha[$urandom_range(0, 6)]);
                bit  v  = ($urandom_range(0, 9) < 8);
                bit  l  = ($urandom_range(0, 9) == 0);
                if (r < 3)
                    rstep(1'b1, 1'b0, 8'h00, v, ch, l);
                else if (r < 7)
                    rstep(1'b0, 1'b1, byte'(pat_alpha[$urandom_range(0, 3)]), v, ch, l);
                else
                    rstep(1'b0, 1'b0, 8'h00, v, ch, v && l);
            end
            cfg_clr = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
